// File: rtl/hermes_switch_control.sv
// -----------------------------------------------------------------------------
// hermes_switch_control
//
// Routing and arbitration control for a 5-port Hermes NoC router. It picks one
// requesting input buffer round-robin, computes its XY route from the head
// flit, and connects it to the target output if that output is free. Each
// connection is torn down when the input's sending flag falls.
//
// Ports
//   clk_i        single clock, all state updates on its rising edge
//   rst_i        synchronous, active-high reset
//   req_i        per-input routing request
//   sending_i    per-input "packet in flight" flag; a 1->0 edge releases it
//   header_i     per-input head flit, target X = [15:8], target Y = [7:0]
//   req_ack_o    one-cycle grant pulse back to the requesting input
//   out_valid_o  per-output "allocated" flag
//   out_sel_o    per-output 3-bit index of the input driving it (crossbar)
//   in_valid_o   per-input "connected" flag
//   in_sel_o     per-input 3-bit index of the output it feeds (credit return)
//
// Port indices: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
// -----------------------------------------------------------------------------
module hermes_switch_control #(
  parameter logic [15:0] ADDRESS   = 16'h0000,
  parameter int          FLIT_SIZE = 32,
  parameter int          NPORT     = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NPORT-1:0]           req_i,
  input  logic [NPORT-1:0]           sending_i,
  input  logic [NPORT*FLIT_SIZE-1:0] header_i,
  output logic [NPORT-1:0]           req_ack_o,
  output logic [NPORT-1:0]           out_valid_o,
  output logic [NPORT*3-1:0]         out_sel_o,
  output logic [NPORT-1:0]           in_valid_o,
  output logic [NPORT*3-1:0]         in_sel_o
);

  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  localparam logic [7:0] LOCAL_X = ADDRESS[15:8];
  localparam logic [7:0] LOCAL_Y = ADDRESS[7:0];

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;        // input being served
  logic [2:0]       target_q, target_d;  // output it wants
  logic [15:0]      hdr_q, hdr_d;        // routing field of its head flit
  logic [2:0]       last_q;              // last granted input (round-robin pointer)

  logic [NPORT-1:0] out_valid_q, in_valid_q;
  logic [2:0]       out_sel_q [NPORT];
  logic [2:0]       in_sel_q  [NPORT];

  logic [NPORT-1:0] sending_q;  // sending_i one cycle ago
  logic [NPORT-1:0] release_q;  // falling edge seen on a connected input

  // ---------------------------------------------------------------------------
  // Head-flit routing fields. Only the low 16 bits carry the destination; the
  // payload bits above them are folded into a deliberately unused signal.
  // ---------------------------------------------------------------------------
  logic [15:0] hdr_arr [NPORT];
  logic        hdr_unused;

  always_comb begin
    hdr_unused = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      hdr_arr[i] = header_i[i*FLIT_SIZE +: 16];
      hdr_unused = hdr_unused ^ (^header_i[i*FLIT_SIZE+16 +: FLIT_SIZE-16]);
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: search starts just after the last granted input and
  // wraps from LOCAL back to EAST. Inputs already connected are not eligible.
  // ---------------------------------------------------------------------------
  logic [NPORT-1:0] eligible;
  logic             found;
  logic [2:0]       rr_idx;
  logic [2:0]       probe;

  always_comb begin
    eligible = req_i & ~in_valid_q;
    found    = 1'b0;
    rr_idx   = EAST;
    probe    = EAST;
    for (int k = 1; k <= NPORT; k++) begin
      probe = 3'((int'(last_q) + k) % NPORT);
      if (!found && eligible[probe]) begin
        found  = 1'b1;
        rr_idx = probe;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // XY routing: resolve X first, then Y; equal on both means deliver locally.
  // ---------------------------------------------------------------------------
  logic [7:0] tgt_x, tgt_y;
  logic [2:0] xy_port;

  always_comb begin
    tgt_x = hdr_q[15:8];
    tgt_y = hdr_q[7:0];
    if (tgt_x > LOCAL_X)      xy_port = EAST;
    else if (tgt_x < LOCAL_X) xy_port = WEST;
    else if (tgt_y > LOCAL_Y) xy_port = NORTH;
    else if (tgt_y < LOCAL_Y) xy_port = SOUTH;
    else                      xy_port = LOCAL;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and grant decision.
  // ---------------------------------------------------------------------------
  logic grant_ok;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    hdr_d     = hdr_q;
    target_d  = target_q;
    grant_ok  = 1'b0;
    req_ack_o = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = rr_idx;
          hdr_d   = hdr_arr[rr_idx];
          state_d = ROUTE;
        end
      end
      ROUTE: begin
        target_d = xy_port;
        state_d  = GRANT;
      end
      GRANT: begin
        // A busy output (including one being released this very cycle, whose
        // valid bit is still set) refuses the grant; arbitration retries later.
        state_d = IDLE;
        if (!out_valid_q[target_q] && !rst_i) begin
          grant_ok         = 1'b1;
          req_ack_o[sel_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, connection tables and release tracking.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sel_q       <= EAST;
      target_q    <= EAST;
      hdr_q       <= '0;
      last_q      <= LOCAL;
      sending_q   <= '0;
      release_q   <= '0;
      out_valid_q <= '0;
      in_valid_q  <= '0;
      // NOTE: the select tables are tiny register arrays that must read zero
      // after reset, so they are cleared here rather than left uninitialised.
      for (int i = 0; i < NPORT; i++) begin
        out_sel_q[i] <= '0;
        in_sel_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      target_q  <= target_d;
      hdr_q     <= hdr_d;
      sending_q <= sending_i;
      // Falls on unconnected inputs are masked out here.
      release_q <= sending_q & ~sending_i & in_valid_q;

      // Tear down released connections. A grant never targets a releasing
      // output or input, so these writes never collide with the grant below.
      for (int i = 0; i < NPORT; i++) begin
        if (release_q[i] && in_valid_q[i]) begin
          in_valid_q[i]              <= 1'b0;
          in_sel_q[i]                <= '0;
          out_valid_q[in_sel_q[i]]   <= 1'b0;
          out_sel_q[in_sel_q[i]]     <= '0;
        end
      end

      if (grant_ok) begin
        out_valid_q[target_q] <= 1'b1;
        out_sel_q[target_q]   <= sel_q;
        in_valid_q[sel_q]     <= 1'b1;
        in_sel_q[sel_q]       <= target_q;
        last_q                <= sel_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  assign out_valid_o = out_valid_q;
  assign in_valid_o  = in_valid_q;

  for (genvar g = 0; g < NPORT; g++) begin : g_flatten
    assign out_sel_o[g*3 +: 3] = out_sel_q[g];
    assign in_sel_o[g*3 +: 3]  = in_sel_q[g];
  end

endmodule

// File: tb/tb_hermes_switch_control.sv
// -----------------------------------------------------------------------------
// tb_hermes_switch_control
//
// Self-checking bench for hermes_switch_control at ADDRESS 16'h1111. Expected
// grants (input, output, cycle) are queued when requests are driven; a monitor
// on the falling clock edge pops and compares each req_ack_o pulse and then
// checks the connection tables the grant should have written.
// -----------------------------------------------------------------------------
module tb_hermes_switch_control;

  localparam int          NP   = 5;
  localparam int          FS   = 32;
  localparam logic [15:0] ADDR = 16'h1111;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   req;
  logic [NP-1:0]   sending;
  logic [NP*FS-1:0] header;
  logic [NP-1:0]   ack;
  logic [NP-1:0]   out_valid;
  logic [NP*3-1:0] out_sel;
  logic [NP-1:0]   in_valid;
  logic [NP*3-1:0] in_sel;

  hermes_switch_control #(
    .ADDRESS  (ADDR),
    .FLIT_SIZE(FS),
    .NPORT    (NP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .sending_i  (sending),
    .header_i   (header),
    .req_ack_o  (ack),
    .out_valid_o(out_valid),
    .out_sel_o  (out_sel),
    .in_valid_o (in_valid),
    .in_sel_o   (in_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard of expected grants.
  typedef struct {
    int port;
    int target;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  exp_t pend_e;
  bit   pend   = 1'b0;
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        pend = 1'b0;
        check("tbl_out_valid", 32'(out_valid[pend_e.target]), 1);
        check("tbl_out_sel",   32'(out_sel[pend_e.target*3 +: 3]), pend_e.port);
        check("tbl_in_valid",  32'(in_valid[pend_e.port]), 1);
        check("tbl_in_sel",    32'(in_sel[pend_e.port*3 +: 3]), pend_e.target);
      end
      if (ack != '0) begin
        check("ack_onehot", 32'($countones(ack) <= 1), 1);
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(ack), 0);
        end else begin
          cur = sb.pop_front();
          check("ack_port",  32'(ack), 32'(5'b1 << cur.port));
          check("ack_cycle", cyc, cur.cyc);
          pend_e = cur;
          pend   = 1'b1;
        end
        // The requesting buffer drops its request once acknowledged.
        req = req & ~ack;
      end
    end
  end

  task automatic next_cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    sending = '0;
    next_cyc(2);
    rst     = 1'b0;
  endtask

  task automatic set_hdr(input int p, input logic [15:0] h);
    header[p*FS +: FS] = {16'h0000, h};
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      next_cyc(1);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
    next_cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  int n0;

  initial begin
    rst     = 1'b1;
    req     = '0;
    sending = '0;
    header  = '0;
    next_cyc(2);
    mon_en = 1'b1;

    // Reset state.
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_valid",  32'(in_valid), 0);
    check("rst_out_sel",   32'(out_sel), 0);
    check("rst_in_sel",    32'(in_sel), 0);
    check("rst_ack",       32'(ack), 0);
    rst = 1'b0;

    // Basic route: LOCAL header 0x2111 from router 0x1111 heads EAST.
    set_hdr(4, 16'h2111);
    req[4] = 1'b1;
    sb.push_back('{4, 0, cyc + 2});
    wait_drain(20);
    check("basic_out_sel_east", 32'(out_sel[2:0]), 4);
    check("basic_in_sel_local", 32'(in_sel[14:12]), 0);
    check("basic_out_valid",    32'(out_valid), 32'(5'b00001));
    check("basic_in_valid",     32'(in_valid), 32'(5'b10000));
    check("basic_idle_sel_zero", 32'({out_sel[14:3], in_sel[11:0]}), 0);

    // Contention: EAST and WEST both want LOCAL. EAST wins; WEST retries every
    // three cycles and is granted at the first GRANT after the release clears.
    do_reset();
    n0 = cyc;
    set_hdr(0, 16'h1111);
    set_hdr(1, 16'h1111);
    req[0] = 1'b1;
    req[1] = 1'b1;
    sb.push_back('{0, 4, n0 + 2});
    sb.push_back('{1, 4, n0 + 14});
    next_cyc(3);                 // n0+3
    sending[0] = 1'b1;
    sending[2] = 1'b1;           // unconnected input
    next_cyc(3);                 // n0+6
    sending[2] = 1'b0;
    next_cyc(2);                 // n0+8
    check("unconn_fall_out_valid", 32'(out_valid), 32'(5'b10000));
    check("unconn_fall_in_valid",  32'(in_valid), 32'(5'b00001));
    next_cyc(2);                 // n0+10 = T
    sending[0] = 1'b0;
    next_cyc(1);                 // T+1
    check("release_t1_still_valid", 32'(out_valid[4]), 1);
    next_cyc(1);                 // T+2
    check("release_t2_out_valid", 32'(out_valid), 0);
    check("release_t2_in_valid",  32'(in_valid), 0);
    check("release_t2_sel_zero",  32'({out_sel, in_sel}), 0);
    wait_drain(30);
    check("contend_out_sel_local", 32'(out_sel[14:12]), 1);

    // Fairness: all five inputs to distinct outputs, grants 0..4 every 3 cycles.
    do_reset();
    n0 = cyc;
    set_hdr(0, 16'h2111);  // EAST
    set_hdr(1, 16'h0111);  // WEST
    set_hdr(2, 16'h1112);  // NORTH
    set_hdr(3, 16'h1110);  // SOUTH
    set_hdr(4, 16'h1111);  // LOCAL
    for (int i = 0; i < NP; i++) sb.push_back('{i, i, n0 + 2 + 3*i});
    req = 5'b11111;
    wait_drain(40);
    check("fair_out_valid", 32'(out_valid), 32'(5'b11111));
    check("fair_in_valid",  32'(in_valid), 32'(5'b11111));

    // Reset mid-packet: three connections (pointer at NORTH) and a request in
    // flight; after the reset pulse everything is dropped and the search
    // restarts at EAST, so WEST beats SOUTH.
    do_reset();
    n0 = cyc;
    set_hdr(0, 16'h2111);
    set_hdr(1, 16'h0111);
    set_hdr(2, 16'h1112);
    for (int i = 0; i < 3; i++) sb.push_back('{i, i, n0 + 2 + 3*i});
    req = 5'b00111;
    wait_drain(30);
    check("pre_rst_in_valid", 32'(in_valid), 32'(5'b00111));
    sending = 5'b00111;
    set_hdr(3, 16'h1110);
    req[3] = 1'b1;               // cycle M, FSM idle
    next_cyc(1);                 // M+1, FSM routing input 3
    rst     = 1'b1;
    req[1]  = 1'b1;
    sending = '0;
    next_cyc(1);                 // M+2, reset applied
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_valid",  32'(in_valid), 0);
    check("midrst_sel_zero",  32'({out_sel, in_sel}), 0);
    sb.push_back('{1, 1, cyc + 2});
    sb.push_back('{3, 3, cyc + 5});
    wait_drain(30);
    check("post_rst_in_valid", 32'(in_valid), 32'(5'b01010));

    next_cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
